// File: rtl/sseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_mux
// Description : Time-multiplexed driver for a bank of common-anode seven-
//               segment digits. A packed hex word plus per-digit blanking is
//               double-buffered so that new values take effect only on frame
//               boundaries. One digit is lit at a time for SCAN_DIV clocks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIGITS     : number of digits scanned (1..8)
//   SCAN_DIV   : clk cycles each digit stays lit (>= 1)
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   data       : hex nibbles, data[4i+3:4i] drives digit i
//   blank      : bit i = 1 forces digit i dark
//   load       : strobe capturing data and blank
//   SSeg       : segments a..g (SSeg[0] = a), active-low, registered
//   an         : anodes, active-low, registered; bits >= DIGITS held 1
//   frame_done : one-cycle pulse on the first output cycle of digit 0
//                following a completed frame
// Configuration macro
//   SSEG_LEADING_ZERO_BLANK_EN : when defined, digit i (i > 0) is also
//                blanked when its nibble and every higher nibble are zero.
// ============================================================================
module sseg_scan_mux #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [0:6]            SSeg,
  output logic [7:0]            an,
  output logic                  frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] c_PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] c_IDX_MAX = IW'(DIGITS - 1);

  // Scan state
  logic [PW-1:0]       r_pre;
  logic [IW-1:0]       r_idx;

  // Shadow buffer collects loads during a frame; active buffer feeds decode
  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [4*DIGITS-1:0] r_act_data;
  logic [DIGITS-1:0]   r_act_blank;
  logic                r_pending;

  // Output stage
  logic [6:0]          r_sseg;
  logic [7:0]          r_an;
  logic                r_wrap_q;
  logic                r_frame_done;

  logic                w_roll;
  logic                w_wrap;
  logic [3:0]          w_nib;
  logic                w_blk;
  logic [6:0]          w_glyph;
  logic [DIGITS-1:0]   w_lz;
  logic                w_zero_above;

  // Prescaler rollover advances the digit; rollover on the last digit is
  // the frame wrap where buffered data is promoted.
  always_comb begin
    w_roll = (r_pre == c_PRE_MAX);
    w_wrap = w_roll && (r_idx == c_IDX_MAX);
  end

  // Leading-zero suppression on the active buffer
  always_comb begin
    w_lz         = '0;
    w_zero_above = 1'b1;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; digit 0 is never suppressed.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_act_data[4*i +: 4] == 4'h0);
      w_lz[i]      = w_zero_above;
    end
`endif
  end

  // Select the nibble and blank flag of the digit currently scanned. A
  // compare-and-select loop keeps the index inside the buffer even when
  // DIGITS is not a power of two.
  always_comb begin
    w_nib = 4'h0;
    w_blk = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib = r_act_data[4*i +: 4];
        w_blk = r_act_blank[i] | w_lz[i];
      end
    end
  end

  // Hex glyphs, bit 6 = segment a ... bit 0 = segment g, active-low
  always_comb begin
    w_glyph = 7'b1111111;
    case (w_nib)
      4'h0: w_glyph = 7'b0000001;
      4'h1: w_glyph = 7'b1001111;
      4'h2: w_glyph = 7'b0010010;
      4'h3: w_glyph = 7'b0000110;
      4'h4: w_glyph = 7'b1001100;
      4'h5: w_glyph = 7'b0100100;
      4'h6: w_glyph = 7'b0100000;
      4'h7: w_glyph = 7'b0001111;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0000100;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b1100000;
      4'hC: w_glyph = 7'b0110001;
      4'hD: w_glyph = 7'b1000010;
      4'hE: w_glyph = 7'b0110000;
      4'hF: w_glyph = 7'b0111000;
      default: w_glyph = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_sh_data    <= '0;
      r_sh_blank   <= '0;
      r_act_data   <= '0;
      r_act_blank  <= '0;
      r_pending    <= 1'b0;
      r_sseg       <= 7'b1111111;
      r_an         <= 8'hFF;
      r_wrap_q     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      // Scan counters
      if (w_roll) begin
        r_pre <= '0;
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      // Double buffering: a load on the wrap cycle bypasses the shadow so
      // it wins over any earlier load in the same frame.
      if (w_wrap) begin
        if (load) begin
          r_act_data  <= data;
          r_act_blank <= blank;
        end else if (r_pending) begin
          r_act_data  <= r_sh_data;
          r_act_blank <= r_sh_blank;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_sh_data  <= data;
        r_sh_blank <= blank;
        r_pending  <= 1'b1;
      end

      // Outputs lag the scan state by one cycle
      r_an   <= ~(8'd1 << r_idx);
      r_sseg <= w_blk ? 7'b1111111 : w_glyph;

      // Delayed twice so the pulse lines up with digit 0 on the pins
      r_wrap_q     <= w_wrap;
      r_frame_done <= r_wrap_q;
    end
  end

  assign SSeg       = r_sseg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
